lsu_unit: RTL

Load/store unit directly downstream of the ALU in the EX→MEM path. Takes the ALU result as effective address plus rs2 store data, runs one data-memory transaction over a req/ack bus with variable latency, and returns sign/zero-extended load data with its destination register to writeback. Misaligned accesses never reach memory; they are reported instead.

---
 rtl/lsu_unit_pkg.sv | 41 ++++
 rtl/lsu_unit_if.sv | 27 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// lsu_unit_pkg: shared LSU op codes, op-field positions, FSM state type,
// the registered request record and the op-legality helper.
package lsu_unit_pkg;

  // Op field layout: bit3 store, bit2 unsigned, bits[1:0] access size
  localparam int OP_STORE_BIT = 3;
  localparam int OP_UNS_BIT   = 2;
  localparam int OP_SIZE_HI   = 1;
  localparam int OP_SIZE_LO   = 0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] LSU_OP_LB  = 4'b0000;
  localparam logic [3:0] LSU_OP_LH  = 4'b0001;
  localparam logic [3:0] LSU_OP_LW  = 4'b0010;
  localparam logic [3:0] LSU_OP_LBU = 4'b0100;
  localparam logic [3:0] LSU_OP_LHU = 4'b0101;
  localparam logic [3:0] LSU_OP_SB  = 4'b1000;
  localparam logic [3:0] LSU_OP_SH  = 4'b1001;
  localparam logic [3:0] LSU_OP_SW  = 4'b1010;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} lsu_state_e;

  // Fields kept from the handshake for load extraction and writeback
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] addr_lo;
    logic [4:0] rd;
  } lsu_req_t;

  // Legal: size 00/01/10; unsigned only on byte/half loads
  function automatic logic lsu_op_legal(input logic [3:0] op);
    logic [1:0] sz;
    sz = op[OP_SIZE_HI:OP_SIZE_LO];
    return (sz != 2'b11) && !(op[OP_STORE_BIT] && op[OP_UNS_BIT]) &&
           !(op[OP_UNS_BIT] && sz == SZ_W);
  endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// lsu_unit_if: groups the EX request, data-memory and writeback buses.
//   slave  - the LSU side (accepts EX ops, drives memory, drives writeback)
//   master - the environment side (EX stage, memory, writeback)
interface lsu_unit_if;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid, out_ready, out_wen, out_misalign;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  modport slave (
    input  in_valid, in_addr, in_wdata, in_op, in_rd, mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_data, out_rd, out_wen, out_misalign
  );

  modport master (
    output in_valid, in_addr, in_wdata, in_op, in_rd, mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           out_valid, out_data, out_rd, out_wen, out_misalign
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the LSU.
//   i_op/i_addr_lo - op code and low address bits
//   i_wdata        - store data, o_wdata/o_wstrb lane-steered bus data/enables
//   i_rdata        - memory word, o_rdata extended load result
//   o_misalign     - legal op whose size does not match the address alignment
module lsu_align
  import lsu_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_uns, w_st, w_mis;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_uns  = i_op[OP_UNS_BIT];
  assign w_st   = i_op[OP_STORE_BIT];

  always_comb begin
    o_wdata = '0;
    o_wstrb = '0;
    o_rdata = '0;
    w_mis   = 1'b0;
    case (i_op[OP_SIZE_HI:OP_SIZE_LO])
      SZ_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wstrb = w_st ? (4'b0001 << i_addr_lo) : 4'b0000;
        o_rdata = w_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        w_mis   = i_addr_lo[0];
        o_wdata = {2{i_wdata[15:0]}};
        o_wstrb = w_st ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b0000;
        o_rdata = w_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SZ_W: begin
        w_mis   = (i_addr_lo != 2'b00);
        o_wdata = i_wdata;
        o_wstrb = w_st ? 4'b1111 : 4'b0000;
        o_rdata = i_rdata;
      end
      default: ;
    endcase
  end

  // No-op codes never fault, whatever the address
  assign o_misalign = lsu_op_legal(i_op) && w_mis;
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: EX->MEM load/store unit. Accepts one op from EX, runs one
// req/ack data-memory transaction, returns extended load data to writeback.
// Misaligned ops and no-op codes skip memory and go straight to the result.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - lsu_unit_if.slave (in_*, mem_*, out_* groups)
module lsu_unit
  import lsu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  lsu_unit_if.slave   bus
);
  lsu_state_e  r_state, w_next;
  lsu_req_t    r_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata, r_out_data;
  logic [3:0]  r_mem_wstrb;
  logic        r_out_wen, r_out_misalign;

  logic        w_idle, w_hs, w_go_mem;
  logic [3:0]  w_al_op;
  logic [1:0]  w_al_addr;
  logic [31:0] w_wdata, w_rdata;
  logic [3:0]  w_wstrb;
  logic        w_misalign;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_hs     = bus.in_valid && w_idle;
  assign w_go_mem = lsu_op_legal(bus.in_op) && !w_misalign;

  // One align instance: in IDLE it sees the incoming op (steering, fault
  // check); afterwards the captured op, for extracting the load word.
  assign w_al_op   = w_idle ? bus.in_op       : r_req.op;
  assign w_al_addr = w_idle ? bus.in_addr[1:0] : r_req.addr_lo;

  lsu_align u_align (
    .i_op       (w_al_op),
    .i_addr_lo  (w_al_addr),
    .i_wdata    (bus.in_wdata),
    .i_rdata    (bus.mem_rdata),
    .o_wdata    (w_wdata),
    .o_wstrb    (w_wstrb),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs) w_next = w_go_mem ? ST_REQ : ST_RESP;
      ST_REQ:  if (bus.mem_ack) w_next = ST_RESP;
      ST_RESP: if (bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req          <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_wstrb    <= '0;
      r_out_data     <= '0;
      r_out_wen      <= 1'b0;
      r_out_misalign <= 1'b0;
    end else if (w_hs) begin
      r_req          <= '{op: bus.in_op, addr_lo: bus.in_addr[1:0], rd: bus.in_rd};
      r_out_data     <= '0;
      r_out_wen      <= 1'b0;
      r_out_misalign <= w_misalign;
      // Memory fields only change when a transaction is actually launched
      if (w_go_mem) begin
        r_mem_we    <= bus.in_op[OP_STORE_BIT];
        r_mem_addr  <= {bus.in_addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_wstrb <= w_wstrb;
      end
    end else if (r_state == ST_REQ && bus.mem_ack && !r_req.op[OP_STORE_BIT]) begin
      r_out_data <= w_rdata;
      r_out_wen  <= (r_req.rd != 5'd0);
    end
  end

  assign bus.in_ready     = w_idle;
  assign bus.mem_req      = (r_state == ST_REQ);
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.mem_wstrb    = r_mem_wstrb;
  assign bus.out_valid    = (r_state == ST_RESP);
  assign bus.out_data     = r_out_data;
  assign bus.out_rd       = r_req.rd;
  assign bus.out_wen      = r_out_wen;
  assign bus.out_misalign = r_out_misalign;
endmodule
